// File: rtl/or1200_cust5_keccak_seq.sv
// Sequencer between the or1200 EX stage and the keccak permutation core for l.cust5.
// Absorbs words into the rate area (START/MIDDLE/END), launches and supervises the
// permutation with a watchdog, and reads state words back to rD (STORE).
module or1200_cust5_keccak_seq #(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned IDX_W       = 6,
  parameter int unsigned STATE_WORDS = 50,
  parameter int unsigned RATE_WORDS  = 34,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_limm,
  input  logic [WORD_W-1:0] cmd_data,
  output logic              res_valid,
  output logic [WORD_W-1:0] res_data,
  output logic              err,
  output logic              core_clr,
  output logic              core_we,
  output logic [IDX_W-1:0]  core_waddr,
  output logic [WORD_W-1:0] core_wdata,
  output logic              core_go,
  input  logic              core_done,
  output logic [IDX_W-1:0]  core_raddr,
  input  logic [WORD_W-1:0] core_rdata,
  output logic [15:0]       blk_cnt
);

  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);

  localparam logic [4:0] OpStart  = 5'b00100;
  localparam logic [4:0] OpMiddle = 5'b00010;
  localparam logic [4:0] OpEnd    = 5'b00001;
  localparam logic [4:0] OpStore  = 5'b01000;

  localparam logic [IDX_W-1:0] PtrLast  = IDX_W'(RATE_WORDS - 1);
  // With a one-word rate the pointer must stay at 0 after START.
  localparam logic [IDX_W-1:0] PtrFirst = (RATE_WORDS > 1) ? IDX_W'(1) : '0;
  localparam logic [IDX_W:0]   StateLim = (IDX_W + 1)'(STATE_WORDS);
  localparam logic [WdogW-1:0] WdogMax  = WdogW'(TIMEOUT);
  localparam logic [WdogW-1:0] WdogOne  = WdogW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StGo,
    StPerm,
    StRd,
    StRsp
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [WdogW-1:0]  wdog_q, wdog_d;
  logic [15:0]       blk_cnt_q, blk_cnt_d;
  logic              res_valid_q, res_valid_d;
  logic [WORD_W-1:0] res_data_q, res_data_d;
  logic              err_q, err_d;
  logic              core_clr_q, core_clr_d;
  logic              core_we_q, core_we_d;
  logic [IDX_W-1:0]  core_waddr_q, core_waddr_d;
  logic [WORD_W-1:0] core_wdata_q, core_wdata_d;
  logic              core_go_q, core_go_d;
  logic [IDX_W-1:0]  core_raddr_q, core_raddr_d;

  logic limm_oob;

  assign limm_oob = ({1'b0, cmd_limm} >= StateLim);

  // Next-state and registered-output logic for the command sequencer.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    wdog_d       = wdog_q;
    blk_cnt_d    = blk_cnt_q;
    res_valid_d  = 1'b0;
    res_data_d   = res_data_q;
    err_d        = 1'b0;
    core_clr_d   = 1'b0;
    core_we_d    = 1'b0;
    core_waddr_d = core_waddr_q;
    core_wdata_d = core_wdata_q;
    core_go_d    = 1'b0;
    core_raddr_d = core_raddr_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OpStart: begin
              // Park the first word on the write bus; it is written after the clear.
              core_clr_d   = 1'b1;
              core_wdata_d = cmd_data;
              state_d      = StClr;
            end
            OpMiddle: begin
              core_we_d    = 1'b1;
              core_waddr_d = ptr_q;
              core_wdata_d = cmd_data;
              if (ptr_q == PtrLast) begin
                state_d = StGo;
              end else begin
                ptr_d = ptr_q + IDX_W'(1);
              end
            end
            OpEnd: begin
              core_we_d    = 1'b1;
              core_waddr_d = ptr_q;
              core_wdata_d = cmd_data;
              state_d      = StGo;
            end
            OpStore: begin
              if (limm_oob) begin
                err_d       = 1'b1;
                res_valid_d = 1'b1;
                res_data_d  = '0;
              end else begin
                core_raddr_d = cmd_limm;
                state_d      = StRd;
              end
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end
      end
      StClr: begin
        core_we_d    = 1'b1;
        core_waddr_d = '0;
        ptr_d        = PtrFirst;
        state_d      = StIdle;
      end
      StGo: begin
        // First cycle raises core_go; second cycle (go visible) arms the watchdog.
        if (!core_go_q) begin
          core_go_d = 1'b1;
          ptr_d     = '0;
        end else begin
          wdog_d  = WdogOne;
          state_d = StPerm;
        end
      end
      StPerm: begin
        if (core_done) begin
          blk_cnt_d = blk_cnt_q + 16'd1;
          wdog_d    = '0;
          state_d   = StIdle;
        end else if (wdog_q == WdogMax) begin
          err_d   = 1'b1;
          wdog_d  = '0;
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + WdogOne;
        end
      end
      StRd: begin
        // Core read data for core_raddr arrives in the next cycle.
        state_d = StRsp;
      end
      StRsp: begin
        res_valid_d = 1'b1;
        res_data_d  = core_rdata;
        state_d     = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      wdog_q       <= '0;
      blk_cnt_q    <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      err_q        <= 1'b0;
      core_clr_q   <= 1'b0;
      core_we_q    <= 1'b0;
      core_waddr_q <= '0;
      core_wdata_q <= '0;
      core_go_q    <= 1'b0;
      core_raddr_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      wdog_q       <= wdog_d;
      blk_cnt_q    <= blk_cnt_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      err_q        <= err_d;
      core_clr_q   <= core_clr_d;
      core_we_q    <= core_we_d;
      core_waddr_q <= core_waddr_d;
      core_wdata_q <= core_wdata_d;
      core_go_q    <= core_go_d;
      core_raddr_q <= core_raddr_d;
    end
  end

  assign cmd_ready  = (state_q == StIdle);
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign err        = err_q;
  assign core_clr   = core_clr_q;
  assign core_we    = core_we_q;
  assign core_waddr = core_waddr_q;
  assign core_wdata = core_wdata_q;
  assign core_go    = core_go_q;
  assign core_raddr = core_raddr_q;
  assign blk_cnt    = blk_cnt_q;

endmodule

// File: tb/tb_or1200_cust5_keccak_seq.sv
// Bench for or1200_cust5_keccak_seq: a behavioural keccak-core stand-in plus a
// sponge-level reference model; directed scenarios followed by random commands.
module tb_or1200_cust5_keccak_seq;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned IDX_W       = 6;
  localparam int unsigned STATE_WORDS = 50;
  localparam int unsigned RATE_WORDS  = 34;
  localparam int unsigned TIMEOUT     = 64;

  localparam logic [4:0] OP_START  = 5'b00100;
  localparam logic [4:0] OP_MIDDLE = 5'b00010;
  localparam logic [4:0] OP_END    = 5'b00001;
  localparam logic [4:0] OP_STORE  = 5'b01000;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [4:0]        cmd_op;
  logic [IDX_W-1:0]  cmd_limm;
  logic [WORD_W-1:0] cmd_data;
  logic              res_valid;
  logic [WORD_W-1:0] res_data;
  logic              err;
  logic              core_clr;
  logic              core_we;
  logic [IDX_W-1:0]  core_waddr;
  logic [WORD_W-1:0] core_wdata;
  logic              core_go;
  logic              core_done;
  logic [IDX_W-1:0]  core_raddr;
  logic [WORD_W-1:0] core_rdata;
  logic [15:0]       blk_cnt;

  or1200_cust5_keccak_seq #(
    .WORD_W      (WORD_W),
    .IDX_W       (IDX_W),
    .STATE_WORDS (STATE_WORDS),
    .RATE_WORDS  (RATE_WORDS),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_limm   (cmd_limm),
    .cmd_data   (cmd_data),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .err        (err),
    .core_clr   (core_clr),
    .core_we    (core_we),
    .core_waddr (core_waddr),
    .core_wdata (core_wdata),
    .core_go    (core_go),
    .core_done  (core_done),
    .core_raddr (core_raddr),
    .core_rdata (core_rdata),
    .blk_cnt    (blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stand-in permutation shared by the core stand-in and the reference model.
  function automatic logic [31:0] perm_word(input logic [31:0] a, input logic [31:0] b,
                                            input int idx);
    return {b[26:0], b[31:27]} ^ ~a ^ (32'h9E3779B9 * 32'(idx));
  endfunction

  // Keccak core stand-in: clear, XOR-absorb, permute on done, one-cycle read latency.
  logic [WORD_W-1:0] mem [STATE_WORDS];
  always @(posedge clk) begin
    if (rst || core_clr) begin
      for (int i = 0; i < int'(STATE_WORDS); i++) mem[i] <= '0;
    end else if (core_done) begin
      for (int i = 0; i < int'(STATE_WORDS); i++)
        mem[i] <= perm_word(mem[i], mem[(i + 7) % int'(STATE_WORDS)], i);
    end else if (core_we && 32'(core_waddr) < STATE_WORDS) begin
      mem[core_waddr] <= mem[core_waddr] ^ core_wdata;
    end
    core_rdata <= (32'(core_raddr) < STATE_WORDS) ? mem[core_raddr] : 32'hBAD0BAD0;
  end

  // Sponge-level reference model.
  logic [31:0] ref_st [STATE_WORDS];
  int          ref_ptr;
  int          ref_blk;
  int          last_raddr;

  task automatic ref_reset();
    for (int i = 0; i < int'(STATE_WORDS); i++) ref_st[i] = '0;
    ref_ptr    = 0;
    ref_blk    = 0;
    last_raddr = 0;
  endtask

  task automatic ref_permute();
    logic [31:0] t [STATE_WORDS];
    for (int i = 0; i < int'(STATE_WORDS); i++) t[i] = ref_st[i];
    for (int i = 0; i < int'(STATE_WORDS); i++)
      ref_st[i] = perm_word(t[i], t[(i + 7) % int'(STATE_WORDS)], i);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    check_eq({tag, "_resv"}, 32'(res_valid), 32'd0);
    check_eq({tag, "_resd"}, res_data, 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
    check_eq({tag, "_clr"}, 32'(core_clr), 32'd0);
    check_eq({tag, "_we"}, 32'(core_we), 32'd0);
    check_eq({tag, "_waddr"}, 32'(core_waddr), 32'd0);
    check_eq({tag, "_wdata"}, core_wdata, 32'd0);
    check_eq({tag, "_go"}, 32'(core_go), 32'd0);
    check_eq({tag, "_raddr"}, 32'(core_raddr), 32'd0);
    check_eq({tag, "_blk"}, 32'(blk_cnt), 32'd0);
  endtask

  // Present one command for a single cycle; returns at the sample point of t+1.
  task automatic issue(input logic [4:0] op, input logic [5:0] limm, input logic [31:0] d);
    check_eq("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_limm  = limm;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 5'($urandom);
    cmd_limm  = 6'($urandom);
    cmd_data  = $urandom;
  endtask

  task automatic do_start(input logic [31:0] d);
    issue(OP_START, 6'($urandom), d);
    check_eq("start_clr", 32'(core_clr), 32'd1);
    check_eq("start_busy", 32'(cmd_ready), 32'd0);
    check_eq("start_no_we", 32'(core_we), 32'd0);
    @(negedge clk);
    check_eq("start_we", 32'(core_we), 32'd1);
    check_eq("start_waddr", 32'(core_waddr), 32'd0);
    check_eq("start_wdata", core_wdata, d);
    check_eq("start_clr_off", 32'(core_clr), 32'd0);
    check_eq("start_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < int'(STATE_WORDS); i++) ref_st[i] = '0;
    ref_st[0] = d;
    ref_ptr   = 1;
  endtask

  // MIDDLE or END; delay = PERM cycle on which done is raised, hang = never raise it.
  task automatic do_absorb(input logic [4:0] op, input logic [31:0] d, input int delay,
                           input bit hang);
    int exp_addr;
    bit perm;
    int n;
    exp_addr = ref_ptr;
    perm     = (op == OP_END) || (ref_ptr == int'(RATE_WORDS) - 1);
    issue(op, 6'($urandom), d);
    check_eq("abs_we", 32'(core_we), 32'd1);
    check_eq("abs_waddr", 32'(core_waddr), 32'(exp_addr));
    check_eq("abs_wdata", core_wdata, d);
    check_eq("abs_err", 32'(err), 32'd0);
    ref_st[exp_addr] = ref_st[exp_addr] ^ d;
    if (!perm) begin
      check_eq("abs_ready", 32'(cmd_ready), 32'd1);
      ref_ptr++;
      return;
    end
    check_eq("go_busy", 32'(cmd_ready), 32'd0);
    check_eq("go_early", 32'(core_go), 32'd0);
    @(negedge clk);
    check_eq("go_pulse", 32'(core_go), 32'd1);
    check_eq("go_no_we", 32'(core_we), 32'd0);
    ref_ptr = 0;
    @(negedge clk);
    check_eq("go_once", 32'(core_go), 32'd0);
    check_eq("perm_busy", 32'(cmd_ready), 32'd0);
    if (!hang) begin
      repeat (delay - 1) @(negedge clk);
      check_eq("perm_wait_ready", 32'(cmd_ready), 32'd0);
      check_eq("perm_wait_err", 32'(err), 32'd0);
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      ref_permute();
      ref_blk++;
      check_eq("done_ready", 32'(cmd_ready), 32'd1);
      check_eq("done_blk", 32'(blk_cnt), 32'(ref_blk % 65536));
      check_eq("done_err", 32'(err), 32'd0);
    end else begin
      n = 0;
      while (err !== 1'b1 && n < int'(TIMEOUT) + 8) begin
        @(negedge clk);
        n++;
      end
      check_eq("wdog_latency", 32'(n), 32'(TIMEOUT));
      check_eq("wdog_ready", 32'(cmd_ready), 32'd1);
      check_eq("wdog_blk", 32'(blk_cnt), 32'(ref_blk % 65536));
      @(negedge clk);
      check_eq("wdog_err_pulse", 32'(err), 32'd0);
      // Late done: the core state changes but the sequencer must not count it.
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      ref_permute();
      check_eq("late_done_blk", 32'(blk_cnt), 32'(ref_blk % 65536));
      check_eq("late_done_err", 32'(err), 32'd0);
      check_eq("late_done_ready", 32'(cmd_ready), 32'd1);
    end
  endtask

  task automatic do_store(input logic [5:0] limm);
    issue(OP_STORE, limm, $urandom);
    if (32'(limm) >= STATE_WORDS) begin
      check_eq("oob_err", 32'(err), 32'd1);
      check_eq("oob_resv", 32'(res_valid), 32'd1);
      check_eq("oob_resd", res_data, 32'd0);
      check_eq("oob_raddr", 32'(core_raddr), 32'(last_raddr));
      check_eq("oob_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      check_eq("oob_err_pulse", 32'(err), 32'd0);
      check_eq("oob_resv_pulse", 32'(res_valid), 32'd0);
    end else begin
      check_eq("st_raddr", 32'(core_raddr), 32'(limm));
      check_eq("st_busy1", 32'(cmd_ready), 32'd0);
      check_eq("st_resv1", 32'(res_valid), 32'd0);
      @(negedge clk);
      check_eq("st_busy2", 32'(cmd_ready), 32'd0);
      check_eq("st_resv2", 32'(res_valid), 32'd0);
      @(negedge clk);
      check_eq("st_resv3", 32'(res_valid), 32'd1);
      check_eq("st_resd", res_data, ref_st[limm]);
      check_eq("st_ready", 32'(cmd_ready), 32'd1);
      check_eq("st_err", 32'(err), 32'd0);
      last_raddr = int'(limm);
    end
  endtask

  task automatic do_illegal(input logic [4:0] op);
    issue(op, 6'($urandom), $urandom);
    check_eq("ill_err", 32'(err), 32'd1);
    check_eq("ill_resv", 32'(res_valid), 32'd0);
    check_eq("ill_core", {29'd0, core_clr, core_we, core_go}, 32'd0);
    check_eq("ill_ready", 32'(cmd_ready), 32'd1);
  endtask

  function automatic logic [4:0] rand_bad_op();
    logic [4:0] op;
    do begin
      op = 5'($urandom_range(0, 31));
    end while (op == OP_START || op == OP_MIDDLE || op == OP_END || op == OP_STORE);
    return op;
  endfunction

  initial begin
    #800000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    int sel;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_limm  = '0;
    cmd_data  = '0;
    core_done = 1'b0;
    rst       = 1'b1;
    ref_reset();
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    @(negedge clk);

    // Basic START/MIDDLE/END flow, permutation done on PERM cycle 24.
    do_start(32'd1);
    do_absorb(OP_MIDDLE, 32'd2, 24, 1'b0);
    do_absorb(OP_END, 32'd3, 24, 1'b0);
    do_store(6'd0);
    do_store(6'd2);

    // Full rate block auto-permutes; next MIDDLE lands at word 0.
    do_start($urandom);
    for (int i = 1; i < int'(RATE_WORDS); i++) do_absorb(OP_MIDDLE, $urandom, 3, 1'b0);
    do_absorb(OP_MIDDLE, $urandom, 1, 1'b0);
    do_store(6'd33);

    // STORE of a known word.
    do_start(32'd0);
    for (int i = 1; i < 15; i++) do_absorb(OP_MIDDLE, 32'd0, 1, 1'b0);
    do_absorb(OP_MIDDLE, 32'hDEADBEEF, 1, 1'b0);
    do_store(6'd15);
    check_eq("deadbeef", res_data, 32'hDEADBEEF);

    // Error paths and watchdog boundaries.
    do_store(6'd50);
    do_store(6'd63);
    do_illegal(5'b00011);
    do_absorb(OP_END, $urandom, int'(TIMEOUT), 1'b0);
    do_absorb(OP_END, $urandom, 0, 1'b1);
    do_store(6'd49);

    // Reset during PERM.
    do_start($urandom);
    issue(OP_END, 6'd0, $urandom);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_perm");
    rst = 1'b0;
    ref_reset();
    @(negedge clk);
    check_eq("rst_perm_go", 32'(core_go), 32'd0);
    check_eq("rst_perm_ready", 32'(cmd_ready), 32'd1);
    do_start($urandom);
    do_absorb(OP_END, $urandom, 5, 1'b0);

    // Reset during RD.
    issue(OP_STORE, 6'd7, $urandom);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_rd");
    rst = 1'b0;
    ref_reset();
    @(negedge clk);
    check_eq("rst_rd_nores", 32'(res_valid), 32'd0);
    @(negedge clk);
    check_eq("rst_rd_nores2", 32'(res_valid), 32'd0);
    do_start($urandom);
    do_absorb(OP_MIDDLE, $urandom, 1, 1'b0);
    do_store(6'd1);

    // Random command stream.
    for (int it = 0; it < 400; it++) begin
      sel = int'($urandom_range(0, 99));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (sel < 10) do_start($urandom);
      else if (sel < 60) do_absorb(OP_MIDDLE, $urandom, int'($urandom_range(1, TIMEOUT)), 1'b0);
      else if (sel < 70)
        do_absorb(OP_END, $urandom, int'($urandom_range(1, TIMEOUT)),
                  ($urandom_range(0, 19) == 0));
      else if (sel < 92) do_store(6'($urandom_range(0, 63)));
      else do_illegal(rand_bad_op());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
